// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: streams sequential ROM words into a small prefetch
// queue and hands them to decode; a redirect flushes everything and restarts fetch.
module fetch_prefetch_unit #(
  parameter int          ADDR_W   = 14,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_en,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [31:0]                imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_pc_plus_4,
  input  logic                       redirect,
  input  logic [31:0]                redirect_target,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;

  logic             pop, push;
  logic [CNT_W:0]   demand;
  logic             unused_target_lsbs;

  // Handshake: an entry transfers when out_valid && out_ready in the same cycle;
  // the head fields stay stable until that happens.
  assign out_valid     = (count_q != '0);
  assign out_instr     = instr_q[head_q];
  assign out_pc        = pc_q[head_q];
  assign out_pc_plus_4 = pc_q[head_q] + 32'd4;
  assign occupancy     = count_q;
  assign imem_addr     = fetch_pc_q[ADDR_W+1:2];

  assign pop  = out_valid & out_ready & ~rst;
  assign push = inflight_q & ~redirect & ~rst;

  // Credit check counts the outstanding ROM read so a capture never overflows.
  assign demand  = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign imem_en = ~rst & ~redirect & (demand < (CNT_W+1)'(DEPTH));

  assign unused_target_lsbs = ^redirect_target[1:0];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = imem_en;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (imem_en) begin
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 32'd4;
    end
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A redirect drops the queue and the outstanding read; any pop this cycle already happened.
    if (redirect) begin
      fetch_pc_d = {redirect_target[31:2], 2'b00};
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[tail_q] <= imem_rdata;
      pc_q[tail_q]    <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: directed timing checks plus a randomized run,
// with an in-order stream model scoring every handshake.
module tb_fetch_prefetch_unit;

  localparam int          ADDR_W   = 8;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic [31:0]       out_pc_plus_4;
  logic              redirect;
  logic [31:0]       redirect_target;
  logic [$clog2(DEPTH):0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_next;

  fetch_prefetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4),
    .redirect(redirect), .redirect_target(redirect_target),
    .occupancy(occupancy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- ROM model ----------------
  function automatic logic [31:0] rom(input logic [ADDR_W-1:0] a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= rom(imem_addr);
    else         imem_rdata <= $urandom;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // The delivered stream is consecutive words from the last reset/redirect point.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      exp_q.delete();
      exp_next = RESET_PC;
    end else begin
      check("valid_vs_occ", 32'(out_valid), 32'(occupancy != 0));
      check("credit", 32'(32'(occupancy) + 32'(u_dut.inflight_q) <= DEPTH), 32'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          exp_q.push_back(exp_next);
          exp_next = exp_next + 32'd4;
        end
        e = exp_q.pop_front();
        check("sb_pc", out_pc, e);
        check("sb_instr", out_instr, rom(e[ADDR_W+1:2]));
        check("sb_pc4", out_pc_plus_4, e + 32'd4);
      end
      if (redirect) begin
        exp_q.delete();
        exp_next = {redirect_target[31:2], 2'b00};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect        = 1'b1;
    redirect_target = t;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; out_ready = 1'b0; redirect = 1'b0; redirect_target = '0;
    next_cycle();
    // Redirect and out_ready must be ignored while in reset.
    out_ready = 1'b1;
    do_redirect(32'h0000_0100);
    next_cycle();
    next_cycle();
    mid();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_imem_en", 32'(imem_en), 32'd0);

    // Test 1: first fetch; cycle 0 is the first cycle with rst low.
    next_cycle();
    rst = 1'b0; redirect = 1'b0; out_ready = 1'b0;
    mid();
    check("c0_imem_en", 32'(imem_en), 32'd1);
    check("c0_imem_addr", 32'(imem_addr), 32'd0);
    next_cycle();
    mid();
    check("c1_valid", 32'(out_valid), 32'd0);
    next_cycle();
    mid();
    check("c2_valid", 32'(out_valid), 32'd1);
    check("c2_pc", out_pc, 32'h0);
    check("c2_instr", out_instr, 32'h1000_0000);
    check("c2_pc4", out_pc_plus_4, 32'h4);

    // Test 3: backpressure fills the queue and freezes fetch.
    for (int i = 0; i < 9; i++) next_cycle();
    mid();
    check("full_occ", 32'(occupancy), DEPTH);
    check("full_imem_en", 32'(imem_en), 32'd0);
    check("full_head_pc", out_pc, 32'h0);

    // Test 2: streaming at full rate, no bubbles.
    next_cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mid();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_pc", out_pc, 32'(i * 4));
      next_cycle();
    end

    // Tests 4/5: redirect with a read in flight and a pop in the same cycle.
    mid();
    check("R_valid", 32'(out_valid), 32'd1);
    next_cycle();
    do_redirect(32'h0000_0203);
    mid();
    check("R_imem_en", 32'(imem_en), 32'd0);
    next_cycle();
    redirect = 1'b0;
    mid();
    check("R1_valid", 32'(out_valid), 32'd0);
    check("R1_imem_en", 32'(imem_en), 32'd1);
    check("R1_imem_addr", 32'(imem_addr), 32'h80);
    next_cycle();
    mid();
    check("R2_valid", 32'(out_valid), 32'd0);
    next_cycle();
    mid();
    check("R3_valid", 32'(out_valid), 32'd1);
    check("R3_pc", out_pc, 32'h200);
    check("R3_instr", out_instr, 32'h1000_0080);

    // Test 6: ROM address wraps while out_pc keeps counting.
    next_cycle();
    do_redirect(32'h0000_03F8);
    next_cycle();
    redirect = 1'b0;
    mid();
    check("W1_imem_addr", 32'(imem_addr), 32'hFE);
    next_cycle();
    next_cycle();
    mid();
    check("W3_imem_addr", 32'(imem_addr), 32'h00);
    check("W3_pc", out_pc, 32'h3F8);
    next_cycle();
    next_cycle();
    mid();
    check("W5_pc", out_pc, 32'h400);
    check("W5_instr", out_instr, 32'h1000_0000);

    // Mid-run reset for one cycle.
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    mid();
    check("M1_valid", 32'(out_valid), 32'd0);
    check("M1_occ", 32'(occupancy), 32'd0);
    check("M1_imem_addr", 32'(imem_addr), 32'(RESET_PC[ADDR_W+1:2]));
    next_cycle();
    next_cycle();
    mid();
    check("M3_valid", 32'(out_valid), 32'd1);
    check("M3_pc", out_pc, RESET_PC);

    // Randomized run: ready, redirects (incl. back-to-back), rare resets.
    for (int i = 0; i < 800; i++) begin
      next_cycle();
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      redirect  = 1'b0;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 2))
          0:       do_redirect($urandom);
          1:       do_redirect(32'($urandom_range(0, 1023)));
          default: do_redirect(32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
        endcase
      end
    end
    next_cycle();
    rst = 1'b0; redirect = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) next_cycle();
    mid();
    check("drain_valid", 32'(out_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
